// File: rtl/jtdsp16_sio_rx.sv
// Serial receiver for the DSP16 serial output port: it assembles 8- or 16-bit
// words with an 8-bit address, keeps those addressed to this station and queues them in a 4-deep show-ahead FIFO.
module jtdsp16_sio_rx (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        ock,
  input  logic        sdo,
  input  logic        ose,
  input  logic        sadd,
  input  logic        len16,
  input  logic [7:0]  my_addr,
  input  logic        rd,
  input  logic        ovf_clr,
  output logic [15:0] dout,
  output logic [7:0]  dout_addr,
  output logic        dout_valid,
  output logic        ovf,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PUSH
  } state_t;

  state_t      state, state_nx;
  logic        ock_l;
  logic        rise;
  logic [3:0]  cnt, cnt_nx;
  logic [15:0] sh_data, sh_data_nx;
  logic [7:0]  sh_addr, sh_addr_nx;
  logic        len_l, len_l_nx;
  logic        last_bit;

  logic [15:0] mem_data [4];
  logic [7:0]  mem_addr [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;
  logic        full, accept, push, pop;

  assign rise     = cen & ock & ~ock_l;
  assign last_bit = len_l ? (cnt == 4'd15) : (cnt == 4'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ock_l   <= 1'b0;
      cnt     <= '0;
      sh_data <= '0;
      sh_addr <= '0;
      len_l   <= 1'b0;
    end else begin
      state   <= state_nx;
      ock_l   <= ock;
      cnt     <= cnt_nx;
      sh_data <= sh_data_nx;
      sh_addr <= sh_addr_nx;
      len_l   <= len_l_nx;
    end
  end

  // A frame sync always starts a fresh word; the shift register is cleared so
  // that 8-bit words come out zero-extended and aborted words leave no residue.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    sh_data_nx = sh_data;
    sh_addr_nx = sh_addr;
    len_l_nx   = len_l;
    case (state)
      IDLE, SHIFT: begin
        if (rise) begin
          if (ose) begin
            sh_data_nx = {15'd0, sdo};
            sh_addr_nx = {7'd0, sadd};
            cnt_nx     = 4'd1;
            len_l_nx   = len16;
            state_nx   = SHIFT;
          end else if (state == SHIFT) begin
            sh_data_nx[cnt] = sdo;
            if (!cnt[3]) sh_addr_nx[cnt[2:0]] = sadd;
            if (last_bit) begin
              cnt_nx   = '0;
              state_nx = PUSH;
            end else begin
              cnt_nx = cnt + 4'd1;
            end
          end
        end
      end
      PUSH:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign dout_valid = (count != 3'd0);
  assign full       = (count == 3'd4);
  assign pop        = rd & dout_valid;
  assign accept     = (state == PUSH) && ((sh_addr == my_addr) || (sh_addr == 8'hFF));
  // A pop in the same cycle frees the slot, so a full FIFO can still take the word.
  assign push       = accept & (~full | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        mem_data[i] <= '0;
        mem_addr[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= sh_data;
        mem_addr[wr_ptr] <= sh_addr;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, push} - {2'b00, pop};
      ovf   <= (accept & full & ~pop) | (ovf & ~ovf_clr);
    end
  end

  assign dout      = dout_valid ? mem_data[rd_ptr] : '0;
  assign dout_addr = dout_valid ? mem_addr[rd_ptr] : '0;
  assign busy      = (state == SHIFT);

endmodule

// File: tb/tb_jtdsp16_sio_rx.sv
// Randomized bench for jtdsp16_sio_rx: a queue-based model of accepted words
// is compared with the FIFO outputs every cycle, plus directed literal checks.
module tb_jtdsp16_sio_rx;

  logic        clk = 1'b0, rst_n = 1'b0, cen = 1'b0, ock = 1'b0, sdo = 1'b0;
  logic        ose = 1'b0, sadd = 1'b0, len16 = 1'b0, rd = 1'b0, ovf_clr = 1'b0;
  logic [7:0]  my_addr = 8'h12;
  logic [15:0] dout;
  logic [7:0]  dout_addr;
  logic        dout_valid, ovf, busy;

  always #5 clk = ~clk;

  jtdsp16_sio_rx dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .ock(ock), .sdo(sdo), .ose(ose),
    .sadd(sadd), .len16(len16), .my_addr(my_addr), .rd(rd), .ovf_clr(ovf_clr),
    .dout(dout), .dout_addr(dout_addr), .dout_valid(dout_valid), .ovf(ovf), .busy(busy)
  );

  typedef struct {
    int          due;
    logic [7:0]  addr;
    logic [15:0] data;
  } word_t;

  word_t pend[$];
  word_t mq[$];
  int    cyc = 0;
  bit    movf = 1'b0;
  int    errors = 0, checks = 0;
  bit    rand_en = 1'b0;
  int    rd_div = 3;
  int    rise_cyc = 0;
  int    vcyc = -1;
  bit    pv = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: words become visible two clock edges after their last ock rise.
  always @(posedge clk or negedge rst_n) begin : model
    word_t w;
    bit    set;
    if (!rst_n) begin
      mq.delete();
      pend.delete();
      movf = 1'b0;
    end else begin
      set = 1'b0;
      cyc++;
      if (rd && mq.size() > 0) void'(mq.pop_front());
      if (pend.size() > 0 && pend[0].due == cyc) begin
        w = pend.pop_front();
        if (w.addr == my_addr || w.addr == 8'hFF) begin
          if (mq.size() < 4) mq.push_back(w);
          else set = 1'b1;
        end
      end
      movf = set || (movf && !ovf_clr);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", 32'(dout_valid), 32'd0);
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_addr", 32'(dout_addr), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end else begin
      chk("valid", 32'(dout_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("dout", 32'(dout), 32'(mq[0].data));
        chk("dout_addr", 32'(dout_addr), 32'(mq[0].addr));
      end
      chk("ovf", 32'(ovf), 32'(movf));
      if (dout_valid && !pv) vcyc = cyc;
    end
    pv = dout_valid;
  end

  task automatic step();
    @(posedge clk); #1;
    cen     = 1'($urandom_range(0, 1));
    sdo     = 1'($urandom_range(0, 1));
    sadd    = 1'($urandom_range(0, 1));
    ose     = 1'($urandom_range(0, 1));
    len16   = 1'($urandom_range(0, 1));
    rd      = rand_en && ($urandom_range(0, rd_div) == 0);
    ovf_clr = rand_en && ($urandom_range(0, 15) == 0);
  endtask

  task automatic send_bit(input logic d, input logic a, input logic o, input logic l,
                          input bit last, input word_t w, input bit pop_p, input bit clr_p);
    word_t ww;
    step();
    ock = 1'b1; cen = 1'b1; sdo = d; sadd = a; ose = o; len16 = l;
    rise_cyc = cyc;
    if (last) begin
      ww = w;
      ww.due = cyc + 2;
      pend.push_back(ww);
    end
    step();
    if (pop_p) rd = 1'b1;
    if (clr_p) ovf_clr = 1'b1;
    if ($urandom_range(0, 1) == 1) step();
    ock = 1'b0;
    repeat ($urandom_range(0, 1)) step();
  endtask

  // ock pulse whose only rising cycle has cen low: must be ignored.
  task automatic ghost();
    step();
    ock = 1'b1; cen = 1'b0;
    step();
    ock = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] data, input logic [7:0] addr, input logic l,
                            input int nbits, input bit pop_p, input bit clr_p);
    int    n;
    word_t w;
    logic  a, lb;
    n = l ? 16 : 8;
    w.due = 0;
    w.addr = addr;
    w.data = l ? data : {8'h00, data[7:0]};
    for (int i = 0; i < nbits; i++) begin
      if (rand_en && $urandom_range(0, 7) == 0) ghost();
      a  = (i < 8) ? addr[i] : 1'($urandom_range(0, 1));
      lb = (i == 0) ? l : 1'($urandom_range(0, 1));
      send_bit(data[i], a, (i == 0), lb, (i == n - 1), w,
               pop_p && (i == n - 1), clr_p && (i == n - 1));
    end
    if (nbits == n) repeat (2) step();
  endtask

  task automatic drain();
    for (int k = 0; k < 8; k++) begin
      if (!dout_valid) break;
      rd = 1'b1;
      step();
    end
    rd = 1'b0;
    chk("drained", 32'(dout_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  ra;
    logic [15:0] rdata;
    logic        rl;
    int          sel;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // 16-bit addressed word, latency and pop
    my_addr = 8'h12;
    send_frame(16'hBEEF, 8'h12, 1'b1, 16, 1'b0, 1'b0);
    chk("w16_dout", 32'(dout), 32'h0000_BEEF);
    chk("w16_addr", 32'(dout_addr), 32'h0000_0012);
    chk("w16_latency", 32'(vcyc - rise_cyc), 32'd2);
    chk("w16_busy", 32'(busy), 32'd0);
    rd = 1'b1; step();
    chk("w16_popped", 32'(dout_valid), 32'd0);

    // 8-bit broadcast
    my_addr = 8'h03;
    send_frame(16'h00A5, 8'hFF, 1'b0, 8, 1'b0, 1'b0);
    chk("bc_dout", 32'(dout), 32'h0000_00A5);
    chk("bc_addr", 32'(dout_addr), 32'h0000_00FF);
    drain();

    // filtered word
    my_addr = 8'h12;
    send_frame(16'h1234, 8'h34, 1'b1, 16, 1'b0, 1'b0);
    chk("filt_valid", 32'(dout_valid), 32'd0);
    chk("filt_ovf", 32'(ovf), 32'd0);

    // overflow on the fifth word
    for (int v = 1; v <= 5; v++) send_frame(16'(v), 8'h12, 1'b1, 16, 1'b0, 1'b0);
    chk("ovf_set", 32'(ovf), 32'd1);
    for (int v = 1; v <= 4; v++) begin
      chk("ovf_pop", 32'(dout), 32'(v));
      rd = 1'b1; step();
    end
    chk("ovf_empty", 32'(dout_valid), 32'd0);
    ovf_clr = 1'b1; step();
    chk("ovf_clr", 32'(ovf), 32'd0);

    // full FIFO, push and pop in the same cycle
    for (int v = 16'h10; v <= 16'h14; v++)
      send_frame(16'(v), 8'h12, 1'b1, 16, (v == 16'h14), 1'b0);
    chk("pp_ovf", 32'(ovf), 32'd0);
    for (int v = 16'h11; v <= 16'h14; v++) begin
      chk("pp_pop", 32'(dout), 32'(v));
      rd = 1'b1; step();
    end
    chk("pp_empty", 32'(dout_valid), 32'd0);

    // overflow and ovf_clr together: set wins
    for (int v = 16'h20; v <= 16'h24; v++)
      send_frame(16'(v), 8'h12, 1'b1, 16, 1'b0, (v == 16'h24));
    chk("setwin_ovf", 32'(ovf), 32'd1);
    drain();
    ovf_clr = 1'b1; step();
    chk("setwin_clr", 32'(ovf), 32'd0);

    // frame sync mid-word restarts the word
    send_frame(16'h1357, 8'h12, 1'b1, 9, 1'b0, 1'b0);
    chk("restart_busy", 32'(busy), 32'd1);
    send_frame(16'hCAFE, 8'h12, 1'b1, 16, 1'b0, 1'b0);
    chk("restart_dout", 32'(dout), 32'h0000_CAFE);
    rd = 1'b1; step();
    chk("restart_single", 32'(dout_valid), 32'd0);

    // reset in the middle of a word with two words queued
    send_frame(16'h0040, 8'h12, 1'b1, 16, 1'b0, 1'b0);
    send_frame(16'h0041, 8'hFF, 1'b0, 8, 1'b0, 1'b0);
    chk("pre_rst_valid", 32'(dout_valid), 32'd1);
    send_frame(16'h5555, 8'h12, 1'b1, 6, 1'b0, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 32'(dout_valid), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("post_rst_valid", 32'(dout_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      word_t dummy;
      dummy.due = 0; dummy.addr = 8'h00; dummy.data = 16'h0000;
      send_bit(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1, 1'b0, dummy, 1'b0, 1'b0);
    end
    chk("post_rst_idle", 32'(busy), 32'd0);
    send_frame(16'h7777, 8'h12, 1'b1, 16, 1'b0, 1'b0);
    chk("post_rst_word", 32'(dout), 32'h0000_7777);
    drain();

    // randomized traffic
    rand_en = 1'b1;
    for (int f = 0; f < 160; f++) begin
      if (f % 20 == 0) rd_div = (f % 40 == 0) ? 3 : 120;
      if ($urandom_range(0, 5) == 0) my_addr = 8'($urandom_range(0, 255));
      sel = $urandom_range(0, 9);
      ra = (sel < 5) ? my_addr : (sel < 7) ? 8'hFF : 8'($urandom_range(0, 255));
      rdata = 16'($urandom);
      rl = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)
        send_frame(16'($urandom), my_addr, 1'b1, $urandom_range(1, 12), 1'b0, 1'b0);
      send_frame(rdata, ra, rl, rl ? 16 : 8, 1'b0, 1'b0);
    end
    rand_en = 1'b0;
    step();
    drain();
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
